mult_rr_scheduler: RTL and testbench

//  Shares one registered signed 32x32 multiplier (2-stage: operand regs, then

---
 rtl/mult_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// Round-robin share of one external 2-stage signed 32x32 multiplier; result MUL_LAT+1 edges after accept.
// One op in flight; req_ready only in IDLE, response held stable until rsp_ready.
module mult_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_x,
  input  logic [32*NUM_REQ-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_z,
  output logic [31:0]           mul_x,
  output logic [31:0]           mul_y,
  input  logic [63:0]           mul_z,
  output logic                  busy,
  output logic [31:0]           op_count
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam int SW    = ID_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     mul_x_q, mul_x_d;
  logic [31:0]     mul_y_q, mul_y_d;
  logic [31:0]     op_count_q, op_count_d;
  logic [63:0]     rsp_z_q, rsp_z_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [31:0]     xs [NUM_REQ];
  logic [31:0]     ys [NUM_REQ];
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign xs[g] = req_x[32*g +: 32];
    assign ys[g] = req_y[32*g +: 32];
  end

  // Scan starts just past the last winner so every requester gets a turn.
  always_comb begin : p_arb
    logic [SW-1:0] scan;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + SW'(k);
      if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
      if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          mul_x_d = xs[gnt_idx];
          mul_y_d = ys[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          cnt_d   = CNT_W'(MUL_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_z_d     = mul_z;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 32'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: external 2-register multiplier model, per-requester
// operand queues, and a response scoreboard checked on every rsp handshake.
module tb_mult_rr_scheduler;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_x, req_y;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [63:0]    rsp_z;
  logic [31:0]    mul_x, mul_y;
  logic [63:0]    mul_z;
  logic           busy;
  logic [31:0]    op_count;

  mult_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .MUL_LAT(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .busy(busy), .op_count(op_count)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0] p1, p2;
  always @(posedge CLK) begin
    p1 <= $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
    p2 <= p1;
  end
  assign mul_z = p2;

  logic        vld_u [N];
  logic [31:0] rx_u [N];
  logic [31:0] ry_u [N];
  logic        rdy_u [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_valid[g]      = vld_u[g];
    assign req_x[32*g +: 32] = rx_u[g];
    assign req_y[32*g +: 32] = ry_u[g];
    assign rdy_u[g]          = req_ready[g];
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] z;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] px_q [N][$];
  logic [31:0] py_q [N][$];
  int          g_id_q [$];
  int          g_cyc_q [$];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_ops;
  logic        rsp_ready_force = 1'b1;
  logic        rnd_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  task automatic issue(input int i, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] z, input bit expect_rsp);
    exp_t e;
    px_q[i].push_back(x);
    py_q[i].push_back(y);
    if (expect_rsp) begin
      e.id = 2'(i);
      e.z  = z;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  // Requester model: holds valid/operands until granted, then moves to its next op.
  initial begin : drv
    logic g [N];
    for (int i = 0; i < N; i++) begin
      vld_u[i] = 1'b0; rx_u[i] = '0; ry_u[i] = '0; g[i] = 1'b0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) g[i] = RESET && rdy_u[i] && vld_u[i];
      if (RESET && req_ready != '0) check("ready_onehot", 64'($countones(req_ready)), 64'd1);
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          void'(px_q[i].pop_front());
          void'(py_q[i].pop_front());
          g_id_q.push_back(i);
          g_cyc_q.push_back(cyc);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (px_q[i].size() > 0) begin
          vld_u[i] = 1'b1; rx_u[i] = px_q[i][0]; ry_u[i] = py_q[i][0];
        end else begin
          vld_u[i] = 1'b0;
        end
      end
    end
  end

  initial begin : rsp_drv
    rsp_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      rsp_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rsp_ready_force;
    end
  end

  initial begin : monitor
    exp_t e;
    exp_ops = '0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        exp_ops = '0;
      end else if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got id=%0d z=%h, want no response", rsp_id, rsp_z);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_z", rsp_z, e.z);
          check("op_count_at_rsp", 64'(op_count), 64'(exp_ops));
          exp_ops = exp_ops + 32'd1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin : stim
    int  k;
    bit  seen;
    int  t2_ord [6];
    logic [31:0] x, y;
    logic [63:0] z;
    t2_ord = '{0, 1, 2, 3, 0, 1};

    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_z", rsp_z, 64'd0);
    check("rst_mul_x", 64'(mul_x), 64'd0);
    check("rst_mul_y", 64'(mul_y), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge CLK); #1; RESET = 1'b1;

    // Fairness: all four requesters valid at once, two ops on 0 and 1.
    @(negedge CLK);
    g_id_q.delete(); g_cyc_q.delete();
    issue(0, 32'd3, 32'd5, 64'd15, 1);
    issue(1, 32'hFFFFFFFE, 32'd4, 64'hFFFFFFFFFFFFFFF8, 1);
    issue(2, 32'd100, 32'd100, 64'h2710, 1);
    issue(3, 32'h00010000, 32'h00010000, 64'h0000000100000000, 1);
    issue(0, 32'hFFFFFFF9, 32'hFFFFFFFA, 64'h2A, 1);
    issue(1, 32'h7FFFFFFF, 32'd2, 64'hFFFFFFFE, 1);
    drain("t2_drain");
    check("t2_grant_count", 64'(g_id_q.size()), 64'd6);
    for (int i = 0; i < g_id_q.size() && i < 6; i++)
      check("t2_grant_order", 64'(g_id_q[i]), 64'(t2_ord[i]));
    for (int i = 1; i < g_cyc_q.size(); i++)
      check("t2_grant_spacing", 64'(g_cyc_q[i] - g_cyc_q[i-1]), 64'd5);

    // Single op on requester 2: grant pulse, latency, result.
    @(negedge CLK);
    issue(2, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge CLK);
      if (req_ready[2]) seen = 1'b1;
    end
    check("t1_grant_seen", 64'(seen), 64'd1);
    k = cyc;
    check("t1_req_ready", 64'(req_ready), 64'b0100);
    @(negedge CLK);
    check("t1_ready_one_cycle", 64'(req_ready), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge CLK);
    end
    check("t1_rsp_seen", 64'(seen), 64'd1);
    check("t1_edges_after_accept", 64'(cyc - (k + 1)), 64'd3);
    drain("t1_drain");
    check("t1_op_count", 64'(op_count), 64'd7);

    // Backpressure: response held for 10 cycles while requester 0 waits.
    rsp_ready_force = 1'b0;
    @(negedge CLK);
    issue(3, 32'h1234, 32'h10, 64'h12340, 1);
    issue(0, 32'd5, 32'd6, 64'd30, 1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    check("t3_rsp_seen", 64'(seen), 64'd1);
    for (int t = 0; t < 10; t++) begin
      check("t3_hold_z", rsp_z, 64'h12340);
      check("t3_hold_id", 64'(rsp_id), 64'd3);
      check("t3_hold_ready", 64'(req_ready), 64'd0);
      check("t3_hold_busy", 64'(busy), 64'd1);
      @(negedge CLK);
    end
    rsp_ready_force = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge CLK);
      if (rsp_valid && rsp_ready) seen = 1'b1;
    end
    check("t3_handshake", 64'(seen), 64'd1);
    @(negedge CLK);
    check("t3_after_valid", 64'(rsp_valid), 64'd0);
    check("t3_after_busy", 64'(busy), 64'd0);
    check("t3_after_ready", 64'(req_ready), 64'b0001);
    drain("t3_drain");

    // Arithmetic corners on requester 1.
    @(negedge CLK);
    issue(1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1);
    issue(1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 1);
    issue(1, 32'h00000000, 32'hFFFFFFFF, 64'h0, 1);
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 1);
    drain("t4_drain");
    check("t4_mul_x_held", 64'(mul_x), 64'hFFFFFFFF);
    check("t4_mul_y_held", 64'(mul_y), 64'hFFFFFFFF);

    // Reset during WAIT aborts the op; arbitration restarts at requester 0.
    @(negedge CLK);
    issue(2, 32'd9, 32'd9, 64'd81, 0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge CLK);
      if (req_ready[2]) seen = 1'b1;
    end
    check("t5_grant_seen", 64'(seen), 64'd1);
    @(posedge CLK);
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_rsp_id", 64'(rsp_id), 64'd0);
    check("t5_rsp_z", rsp_z, 64'd0);
    check("t5_mul_x", 64'(mul_x), 64'd0);
    check("t5_mul_y", 64'(mul_y), 64'd0);
    check("t5_op_count", 64'(op_count), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    @(posedge CLK); #1; RESET = 1'b1;
    @(negedge CLK);
    g_id_q.delete(); g_cyc_q.delete();
    issue(0, 32'd4, 32'd5, 64'd20, 1);
    issue(1, 32'd2, 32'd3, 64'd6, 1);
    drain("t5_drain");
    check("t5_grant_count", 64'(g_id_q.size()), 64'd2);
    if (g_id_q.size() > 0) check("t5_first_grant", 64'(g_id_q[0]), 64'd0);
    check("t5_op_count_after", 64'(op_count), 64'd2);

    // Random operands and response backpressure, reference product by id.
    rnd_mode = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      x = $urandom();
      y = $urandom();
      z = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      issue(int'($urandom_range(0, N - 1)), x, y, z, 1);
      drain("t6_drain");
    end
    rnd_mode = 1'b0;

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
